// File: rtl/regfile_if.sv
// Register file port bundle: writeback write port, two decode read ports and
// the committed-write counter.
interface regfile_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
);
   logic                  RegWrite_WB;
   logic [ADDR_WIDTH-1:0] rd_addr_WB;
   logic [DATA_WIDTH-1:0] write_back_WB;
   logic [ADDR_WIDTH-1:0] rs1_addr_ID;
   logic [ADDR_WIDTH-1:0] rs2_addr_ID;
   logic [DATA_WIDTH-1:0] rs1_data_ID;
   logic [DATA_WIDTH-1:0] rs2_data_ID;
   logic [31:0]           wr_count;

   // Pipeline side: drives the write port and read addresses
   modport master (
      output RegWrite_WB, rd_addr_WB, write_back_WB, rs1_addr_ID, rs2_addr_ID,
      input  rs1_data_ID, rs2_data_ID, wr_count
   );

   // Register file side
   modport slave (
      input  RegWrite_WB, rd_addr_WB, write_back_WB, rs1_addr_ID, rs2_addr_ID,
      output rs1_data_ID, rs2_data_ID, wr_count
   );
endinterface

// File: rtl/regfile.sv
// Integer register file: one write port, two combinational read ports, x0
// hardwired to zero, and a counter of committed (non-x0) writes.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the
// read ports; without it a write becomes visible on the following cycle.
module regfile #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_COUNT  = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic      clk,
   input  logic      rst_n,
   regfile_if.slave  bus
);

   localparam int unsigned CNT_WIDTH = 32;

   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
   logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
   logic [CNT_WIDTH-1:0]  wr_count_q;
   logic [CNT_WIDTH-1:0]  wr_count_d;
   logic                  wr_commit_c;
   logic [DATA_WIDTH-1:0] rs1_data_c;
   logic [DATA_WIDTH-1:0] rs2_data_c;

   // A write commits only when enabled and not aimed at x0
   assign wr_commit_c = bus.RegWrite_WB && (bus.rd_addr_WB != ADDR_WIDTH'(0));

   // Next-state for storage and the committed-write counter (wraps naturally)
   always_comb begin
      regs_d     = regs_q;
      wr_count_d = wr_count_q;
      if (wr_commit_c) begin
         regs_d[bus.rd_addr_WB] = bus.write_back_WB;
         wr_count_d             = wr_count_q + CNT_WIDTH'(1);
      end
      regs_d[0] = '0;
   end

   // State registers; reset clears everything and dominates any write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(REG_COUNT); i++) begin
            regs_q[i] <= '0;
         end
         wr_count_q <= '0;
      end else begin
         regs_q     <= regs_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Combinational read ports; x0 always reads zero
   always_comb begin
      rs1_data_c = (bus.rs1_addr_ID == ADDR_WIDTH'(0)) ? '0 : regs_q[bus.rs1_addr_ID];
      rs2_data_c = (bus.rs2_addr_ID == ADDR_WIDTH'(0)) ? '0 : regs_q[bus.rs2_addr_ID];
`ifdef REGFILE_BYPASS_EN
      // Same-cycle forwarding; wr_commit_c already excludes x0, and reset blocks it
      if (rst_n && wr_commit_c && (bus.rs1_addr_ID == bus.rd_addr_WB)) begin
         rs1_data_c = bus.write_back_WB;
      end
      if (rst_n && wr_commit_c && (bus.rs2_addr_ID == bus.rd_addr_WB)) begin
         rs2_data_c = bus.write_back_WB;
      end
`endif
   end

   assign bus.rs1_data_ID = rs1_data_c;
   assign bus.rs2_data_ID = rs2_data_c;
   assign bus.wr_count    = wr_count_q;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: table of single-cycle vectors plus hand-written
// sequences for bypass, mid-period reset, reset-dominated writes and counter wrap.
module tb_regfile;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   regfile #(.DATA_WIDTH(DW), .REG_COUNT(32), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [AW-1:0] rd;
      logic [DW-1:0] wd;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [DW-1:0] exp1;
      logic [DW-1:0] exp2;
      logic [31:0]   exp_cnt;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] wd,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
      bus.RegWrite_WB   = we;
      bus.rd_addr_WB    = rd;
      bus.write_back_WB = wd;
      bus.rs1_addr_ID   = rs1;
      bus.rs2_addr_ID   = rs2;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      // Each row: driven after negedge, checked 1 time unit later, committed at posedge
      vecs[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd1,  5'd2,  32'h0,         32'h0,         32'd0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1};
      vecs[2]  = '{1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd5,  32'h0,         32'hDEAD_BEEF, 32'd1};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0,         32'd1};
      vecs[4]  = '{1'b1, 5'd7,  32'h0000_0011, 5'd5,  5'd6,  32'hDEAD_BEEF, 32'h0,         32'd1};
      vecs[5]  = '{1'b1, 5'd9,  32'hCAFE_F00D, 5'd7,  5'd3,  32'h0000_0011, 32'h0,         32'd2};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,         5'd9,  5'd7,  32'hCAFE_F00D, 32'h0000_0011, 32'd3};
      vecs[7]  = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd9,  5'd9,  32'hCAFE_F00D, 32'hCAFE_F00D, 32'd3};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd1,  32'hFFFF_FFFF, 32'h0,         32'd4};
      vecs[9]  = '{1'b0, 5'd5,  32'h0,         5'd5,  5'd7,  32'hDEAD_BEEF, 32'h0000_0011, 32'd4};
      vecs[10] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd31, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd4};

      // Reset state: every index reads zero on both ports
      drive(1'b0, '0, '0, '0, '0);
      rst_n = 1'b0;
      #12;
      for (int i = 0; i < 32; i++) begin
         bus.rs1_addr_ID = AW'(i);
         bus.rs2_addr_ID = AW'(31 - i);
         #1;
         check($sformatf("reset_rs1_x%0d", i), bus.rs1_data_ID, 32'h0);
         check($sformatf("reset_rs2_x%0d", 31 - i), bus.rs2_data_ID, 32'h0);
      end
      check("reset_wr_count", bus.wr_count, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int v = 0; v < 11; v++) begin
         drive(vecs[v].we, vecs[v].rd, vecs[v].wd, vecs[v].rs1, vecs[v].rs2);
         #1;
         check($sformatf("vec%0d_rs1", v), bus.rs1_data_ID, vecs[v].exp1);
         check($sformatf("vec%0d_rs2", v), bus.rs2_data_ID, vecs[v].exp2);
         check($sformatf("vec%0d_cnt", v), bus.wr_count, vecs[v].exp_cnt);
         @(negedge clk);
      end

      // Same-cycle write/read of x7 (holds 0x11)
      drive(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd0, 5'd7);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("bypass_rs2_same_cycle", bus.rs2_data_ID, 32'hA5A5_A5A5);
`else
      check("nobypass_rs2_same_cycle", bus.rs2_data_ID, 32'h0000_0011);
`endif
      check("bypass_x0_rs1", bus.rs1_data_ID, 32'h0);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
      #1;
      check("x7_next_cycle", bus.rs2_data_ID, 32'hA5A5_A5A5);
      check("cnt_after_x7", bus.wr_count, 32'd5);

      // x0 write with x0 read: never forwarded
      drive(1'b1, 5'd0, 32'hFFFF_0000, 5'd0, 5'd0);
      #1;
      check("x0_no_bypass", bus.rs1_data_ID, 32'h0);
      @(negedge clk);

      // Fill x1..x31 with their index
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, AW'(i), DW'(i), 5'd0, 5'd0);
         @(negedge clk);
      end
      drive(1'b0, 5'd0, 32'h0, 5'd17, 5'd31);
      #1;
      check("fill_x17", bus.rs1_data_ID, 32'd17);
      check("fill_x31", bus.rs2_data_ID, 32'd31);
      check("fill_cnt", bus.wr_count, 32'd36);

      // Mid-period asynchronous reset clears state immediately
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset_cnt", bus.wr_count, 32'h0);
      for (int i = 1; i < 32; i++) begin
         bus.rs1_addr_ID = AW'(i);
         #1;
         check($sformatf("midreset_x%0d", i), bus.rs1_data_ID, 32'h0);
      end

      // Write during reset is lost and not forwarded
      @(negedge clk);
      drive(1'b1, 5'd4, 32'h4444_4444, 5'd4, 5'd4);
      #1;
      check("reset_write_no_bypass", bus.rs1_data_ID, 32'h0);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
      #1;
      check("reset_write_lost", bus.rs1_data_ID, 32'h0);
      check("reset_write_cnt", bus.wr_count, 32'h0);

      // First edge after deassertion accepts a write
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 5'd4, 32'h0000_0044, 5'd1, 5'd2);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd1);
      #1;
      check("post_reset_x4", bus.rs1_data_ID, 32'h0000_0044);
      check("post_reset_x1", bus.rs2_data_ID, 32'h0);
      check("post_reset_cnt", bus.wr_count, 32'd1);

      // Counter wrap from all-ones
      force dut.wr_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.wr_count_q;
      drive(1'b1, 5'd3, 32'h0000_0033, 5'd0, 5'd0);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
      #1;
      check("wrap_cnt", bus.wr_count, 32'h0);
      check("wrap_x3", bus.rs1_data_ID, 32'h0000_0033);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32 (from defines package), register width in bits.
REQ-002 The block SHALL have parameter REG_COUNT, default 32, number of architectural integer registers.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 5, register index width; REG_COUNT SHALL equal 2**ADDR_WIDTH.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port RegWrite_WB  input  1  write enable from writeback stage.
REQ-007 The block SHALL have port rd_addr_WB  input  ADDR_WIDTH  destination register index.
REQ-008 The block SHALL have port write_back_WB  input  DATA_WIDTH  selected writeback data.
REQ-009 The block SHALL have port rs1_addr_ID  input  ADDR_WIDTH  first source index from decode.
REQ-010 The block SHALL have port rs2_addr_ID  input  ADDR_WIDTH  second source index from decode.
REQ-011 The block SHALL have port rs1_data_ID  output  DATA_WIDTH  first source operand.
REQ-012 The block SHALL have port rs2_data_ID  output  DATA_WIDTH  second source operand.
REQ-013 The block SHALL have port wr_count  output  32  count of committed (non-x0) register writes since reset.

Function
REQ-014 Storage SHALL be REG_COUNT x DATA_WIDTH flops; x0 SHALL read 0 always and SHALL NOT be writable.
REQ-015 On rising clk with rst_n=1, RegWrite_WB=1 and rd_addr_WB!=0, register[rd_addr_WB] SHALL take write_back_WB.
REQ-016 A write with rd_addr_WB=0 SHALL be discarded and SHALL NOT increment wr_count.
REQ-017 Reads SHALL be combinational: rsN_data_ID = register[rsN_addr_ID], zero latency, both ports independent.
REQ-018 rs1 and rs2 addressing the same register SHALL both return the same value.
REQ-019 wr_count SHALL increment by 1 on each committed write (REQ-015) and wrap from 0xFFFF_FFFF to 0.
REQ-020 Only one write per cycle; no read port SHALL ever modify state.

Reset
REQ-021 rst_n=0 SHALL asynchronously clear every register and wr_count to 0, independent of clk.
REQ-022 A write coincident with an asserted rst_n SHALL be lost; reset dominates.
REQ-023 After rst_n deassertion, the first rising clk SHALL accept writes normally.
REQ-024 During reset, rs1_data_ID and rs2_data_ID SHALL read 0 for every index (bypass, if compiled, SHALL be suppressed).

Configuration
REQ-025 Macro REGFILE_BYPASS_EN SHALL select write-to-read bypass.
REQ-026 With REGFILE_BYPASS_EN defined: if RegWrite_WB=1, rd_addr_WB!=0, rst_n=1 and rsN_addr_ID==rd_addr_WB, rsN_data_ID SHALL equal write_back_WB in the same cycle.
REQ-027 Without REGFILE_BYPASS_EN: reads SHALL return the stored value only; a same-cycle write SHALL be visible from the next cycle; hazard resolution is the forwarding unit's job.
REQ-028 Bypass SHALL never apply to x0.

Verification
REQ-029 Reset, then read all 32 indices on both ports -> every value 0, wr_count=0.
REQ-030 Write x5=0xDEAD_BEEF, next cycle rs1=5, rs2=5 -> both 0xDEAD_BEEF, wr_count=1.
REQ-031 Write x0=0x1234_5678 -> rs1=0 reads 0, wr_count unchanged.
REQ-032 Same cycle write x7=0xA5A5_A5A5 while rs2=7 (x7 held 0x11) -> 0xA5A5_A5A5 with REGFILE_BYPASS_EN, 0x11 without; 0xA5A5_A5A5 next cycle either way.
REQ-033 Write x1..x31 with index values, pulse rst_n low mid-clock-period (not at edge) -> all registers and wr_count read 0 immediately.
REQ-034 Preload wr_count to 0xFFFF_FFFF via forced state, commit one write to x3 -> wr_count=0, x3 updated.
